trace_axis_mem_sink: RTL and testbench
======================================

// Module: trace_axis_mem_sink
// PURPOSE
//  Receive end of the role's 512-bit AXI-Stream trace port (m_axis_trace_*).
//  Packs trace beats into fixed-length 256-bit AXI4 write bursts into a power-of-two ring buffer in memory.
//  Sits in the shell between the role trace master and the memory-side interconnect.
//  Status counters are exported to shell control registers.
// PARAMETERS
//  IN_W        512  s_axis tdata width (bits)
//  MEM_W       256  AXI4 wdata width (bits); IN_W == 2*MEM_W
//  ADDR_W      48   AXI4 address width
//  ID_W        14   AXI4 ID width
//  AXI_ID      0    constant awid value
//  BURST_BEATS 16   AXI beats per burst (512 bytes); staging depth = BURST_BEATS/2 input beats
// PORTS
//  aclk                 in   1        clock
//  aresetn              in   1        async active-low reset
//  s_axis_trace_tvalid  in   1        trace beat valid
//  s_axis_trace_tready  out  1        trace beat accept
//  s_axis_trace_tdata   in   IN_W     trace payload
//  s_axis_trace_tkeep   in   IN_W/8   byte enables
//  s_axis_trace_tlast   in   1        end of trace record; forces burst flush
//  m_axi_awid/awaddr    out  ID_W/ADDR_W
//  m_axi_awlen/awsize/awburst  out  8/3/2
//  m_axi_awvalid        out  1;  m_axi_awready in 1
//  m_axi_wdata/wstrb    out  MEM_W/MEM_W/8
//  m_axi_wlast/wvalid   out  1/1;  m_axi_wready in 1
//  m_axi_bid/bresp      in   ID_W/2;  m_axi_bvalid in 1;  m_axi_bready out 1
//  cfg_enable           in   1        accept new trace data
//  cfg_base             in   ADDR_W   ring base; bits [8:0] must be 0
//  cfg_mask             in   ADDR_W   ring size-1; must be 2^n-1, n>=9
//  cfg_clear            in   1        pulse: zero offset/wraps/err
//  stat_offset          out  ADDR_W   next write offset within ring
//  stat_wraps           out  32       ring wrap count (saturates at all-ones)
//  stat_err             out  1        sticky: any bresp != OKAY
//  stat_busy            out  1        state != FILL, or staging not empty
// BEHAVIOUR
//  Reset: state=FILL, staging empty, all valid/ready/last outputs 0, offset/wraps/err 0.
//  Reset mid-transaction: in-flight burst is abandoned.
//  Constant outputs: awid=AXI_ID, awlen=BURST_BEATS-1, awsize=5, awburst=INCR. awaddr=cfg_base+stat_offset, registered.
//  Bursts are 512-byte aligned, so no burst crosses a 4KB boundary.
//  FILL:
//   - tready = cfg_enable & staging not full & !cfg_clear.
//   - Each accepted beat is written to staging entry cnt; cnt++.
//   - Go to ADDR next cycle when cnt reaches BURST_BEATS/2, or when an accepted beat has tlast.
//  ADDR: awvalid=1, held stable until awready; then go to DATA. tready=0.
//  DATA:
//   - wvalid=1; AXI beat k (0..BURST_BEATS-1) uses entry k/2.
//   - k even: low half (tdata[255:0], tkeep[31:0]). k odd: high half (tdata[511:256], tkeep[63:32]).
//   - Entries >= cnt are sent with wdata=0, wstrb=0 (padding).
//   - wlast=1 on k=BURST_BEATS-1. Advance only on wready; after the last beat go to RESP.
//  RESP:
//   - bready=1. On bvalid: if bresp != 0, set stat_err.
//   - offset <= (offset+512) & cfg_mask. If the result is 0, wraps++.
//   - cnt <= 0; go to FILL.
//  cfg_enable low mid-burst: the current burst completes normally; FILL then holds tready=0.
//  cfg_clear: honoured only in FILL with cnt==0; ignored otherwise, and never blocks an active burst.
//   Simultaneous clear and bvalid is impossible (states differ).
//  W is never issued before the AW handshake. AW/W/B are serial: one burst outstanding.
//  Throughput bound: one burst per (BURST_BEATS/2 fill + 1 AW + BURST_BEATS W + 1 B) cycles minimum.
// TESTING
//  1) base=0x1_0000_0000, mask=0xFFFF, 8 full beats
//     -> AW addr 0x1_0000_0000, len 15, size 5, INCR.
//     -> 16 W beats in lo/hi order, wlast on beat 16; stat_offset=0x200.
//  2) tlast on 3rd beat -> 16 W beats; beats 1-6 carry data, beats 7-16 wstrb=0 and wdata=0.
//  3) mask=0x3FF, 3 bursts -> awaddr base, base+0x200, base; stat_wraps=1, stat_offset=0x200.
//  4) awready held 0 for 20 cycles after fill -> awvalid stable, tready=0, wvalid=0 throughout.
//  5) bresp=SLVERR on burst 1, OKAY on burst 2 -> stat_err stays 1; offset still advances to 0x400.
//  6) aresetn low during DATA beat 5 -> all outputs at reset values next edge.
//     Next burst starts at offset 0 with a fresh fill.

Source files
------------

// File: rtl/trace_axis_mem_sink.sv
// Packs 512-bit AXI-Stream trace beats into fixed 16x256-bit AXI4 INCR bursts into a ring buffer.
// Latency: AW issues the cycle after the last staged beat; one burst outstanding (fill -> AW -> W -> B).
// Backpressure: tready drops outside FILL, when staging is full, when disabled, or during cfg_clear.
module trace_axis_mem_sink #(
  parameter int IN_W        = 512,
  parameter int MEM_W       = 256,
  parameter int ADDR_W      = 48,
  parameter int ID_W        = 14,
  parameter int AXI_ID      = 0,
  parameter int BURST_BEATS = 16
) (
  input  logic                aclk,
  input  logic                aresetn,
  input  logic                s_axis_trace_tvalid,
  output logic                s_axis_trace_tready,
  input  logic [IN_W-1:0]     s_axis_trace_tdata,
  input  logic [IN_W/8-1:0]   s_axis_trace_tkeep,
  input  logic                s_axis_trace_tlast,
  output logic [ID_W-1:0]     m_axi_awid,
  output logic [ADDR_W-1:0]   m_axi_awaddr,
  output logic [7:0]          m_axi_awlen,
  output logic [2:0]          m_axi_awsize,
  output logic [1:0]          m_axi_awburst,
  output logic                m_axi_awvalid,
  input  logic                m_axi_awready,
  output logic [MEM_W-1:0]    m_axi_wdata,
  output logic [MEM_W/8-1:0]  m_axi_wstrb,
  output logic                m_axi_wlast,
  output logic                m_axi_wvalid,
  input  logic                m_axi_wready,
  input  logic [ID_W-1:0]     m_axi_bid,
  input  logic [1:0]          m_axi_bresp,
  input  logic                m_axi_bvalid,
  output logic                m_axi_bready,
  input  logic                cfg_enable,
  input  logic [ADDR_W-1:0]   cfg_base,
  input  logic [ADDR_W-1:0]   cfg_mask,
  input  logic                cfg_clear,
  output logic [ADDR_W-1:0]   stat_offset,
  output logic [31:0]         stat_wraps,
  output logic                stat_err,
  output logic                stat_busy
);

  localparam int DEPTH       = BURST_BEATS / 2;
  localparam int CNT_W       = $clog2(DEPTH + 1);
  localparam int IDX_W       = $clog2(DEPTH);
  localparam int K_W         = $clog2(BURST_BEATS);
  localparam int KEEP_W      = IN_W / 8;
  localparam int STRB_W      = MEM_W / 8;
  localparam int BURST_BYTES = BURST_BEATS * STRB_W;

  typedef enum logic [1:0] {S_FILL, S_ADDR, S_DATA, S_RESP} state_t;

  state_t              state;
  logic [CNT_W-1:0]    cnt;
  logic [K_W-1:0]      k;
  logic                live;
  logic                awvalid_q;
  logic                wvalid_q;
  logic                bready_q;
  logic [ADDR_W-1:0]   awaddr_q;
  logic [ADDR_W-1:0]   offset;
  logic [31:0]         wraps;
  logic                err;

  logic [IN_W-1:0]     stage_data [DEPTH];
  logic [KEEP_W-1:0]   stage_keep [DEPTH];

  logic                accept;
  logic [IDX_W-1:0]    entry;
  logic                pad;
  logic [ADDR_W-1:0]   offset_next;
  logic                unused_bid;

  // The write response ID is not needed: only one burst is ever outstanding.
  assign unused_bid = ^m_axi_bid;

  // live keeps tready low while aresetn is asserted, regardless of cfg_enable.
  assign s_axis_trace_tready = live && (state == S_FILL) && cfg_enable &&
                               (cnt < CNT_W'(DEPTH)) && !cfg_clear;
  assign accept      = s_axis_trace_tvalid && s_axis_trace_tready;
  assign entry       = k[K_W-1:1];
  assign pad         = (CNT_W'(entry) >= cnt);
  assign offset_next = (offset + ADDR_W'(BURST_BYTES)) & cfg_mask;

  assign m_axi_awid    = ID_W'(AXI_ID);
  assign m_axi_awlen   = 8'(BURST_BEATS - 1);
  assign m_axi_awsize  = 3'($clog2(STRB_W));
  assign m_axi_awburst = 2'b01;
  assign m_axi_awaddr  = awaddr_q;
  assign m_axi_awvalid = awvalid_q;
  assign m_axi_wvalid  = wvalid_q;
  assign m_axi_wlast   = wvalid_q && (k == K_W'(BURST_BEATS - 1));
  assign m_axi_bready  = bready_q;
  assign stat_offset   = offset;
  assign stat_wraps    = wraps;
  assign stat_err      = err;
  assign stat_busy     = (state != S_FILL) || (cnt != '0);

  // Select the half-entry for W beat k; entries never filled go out as zero-strobe padding.
  always_comb begin
    m_axi_wdata = '0;
    m_axi_wstrb = '0;
    if (!pad) begin
      if (k[0]) begin
        m_axi_wdata = stage_data[entry][IN_W-1:MEM_W];
        m_axi_wstrb = stage_keep[entry][KEEP_W-1:STRB_W];
      end else begin
        m_axi_wdata = stage_data[entry][MEM_W-1:0];
        m_axi_wstrb = stage_keep[entry][STRB_W-1:0];
      end
    end
  end

  // Staging storage holds payload only; validity is tracked by cnt, so no reset is needed.
  always_ff @(posedge aclk) begin
    if (accept) begin
      stage_data[cnt[IDX_W-1:0]] <= s_axis_trace_tdata;
      stage_keep[cnt[IDX_W-1:0]] <= s_axis_trace_tkeep;
    end
  end

  // Burst sequencer: fill staging, issue AW, stream W, retire B and advance the ring offset.
  always_ff @(posedge aclk or negedge aresetn) begin
    if (!aresetn) begin
      state     <= S_FILL;
      cnt       <= '0;
      k         <= '0;
      live      <= 1'b0;
      awvalid_q <= 1'b0;
      wvalid_q  <= 1'b0;
      bready_q  <= 1'b0;
      awaddr_q  <= '0;
      offset    <= '0;
      wraps     <= '0;
      err       <= 1'b0;
    end else begin
      live <= 1'b1;
      case (state)
        S_FILL: begin
          if (accept) begin
            cnt <= cnt + 1'b1;
            if ((cnt == CNT_W'(DEPTH - 1)) || s_axis_trace_tlast) begin
              state     <= S_ADDR;
              awvalid_q <= 1'b1;
              awaddr_q  <= cfg_base + offset;
            end
          end else if (cfg_clear && (cnt == '0)) begin
            offset <= '0;
            wraps  <= '0;
            err    <= 1'b0;
          end
        end
        S_ADDR: begin
          if (m_axi_awready) begin
            awvalid_q <= 1'b0;
            wvalid_q  <= 1'b1;
            k         <= '0;
            state     <= S_DATA;
          end
        end
        S_DATA: begin
          if (m_axi_wready) begin
            if (k == K_W'(BURST_BEATS - 1)) begin
              wvalid_q <= 1'b0;
              bready_q <= 1'b1;
              state    <= S_RESP;
            end else begin
              k <= k + 1'b1;
            end
          end
        end
        S_RESP: begin
          if (m_axi_bvalid) begin
            bready_q <= 1'b0;
            err      <= err | (m_axi_bresp != 2'b00);
            offset   <= offset_next;
            if ((offset_next == '0) && (wraps != '1)) begin
              wraps <= wraps + 32'd1;
            end
            cnt   <= '0;
            state <= S_FILL;
          end
        end
        default: state <= S_FILL;
      endcase
    end
  end

endmodule

// File: tb/tb_trace_axis_mem_sink.sv
// Directed + randomized bench for trace_axis_mem_sink with a queue-based burst/ring model.
// Inputs change 1ns after the rising edge; outputs are sampled there too.
// Memory side (awready/wready/bvalid) is driven by the bench with random stalls.
module tb_trace_axis_mem_sink;
  localparam int IN_W   = 512;
  localparam int MEM_W  = 256;
  localparam int ADDR_W = 48;
  localparam int ID_W   = 14;
  localparam int BB     = 16;
  localparam int DEPTH  = 8;

  logic               aclk = 1'b0;
  logic               aresetn;
  logic               tvalid, tready, tlast;
  logic [IN_W-1:0]    tdata;
  logic [IN_W/8-1:0]  tkeep;
  logic [ID_W-1:0]    awid;
  logic [ADDR_W-1:0]  awaddr;
  logic [7:0]         awlen;
  logic [2:0]         awsize;
  logic [1:0]         awburst;
  logic               awvalid, awready;
  logic [MEM_W-1:0]   wdata;
  logic [MEM_W/8-1:0] wstrb;
  logic               wlast, wvalid, wready;
  logic [ID_W-1:0]    bid;
  logic [1:0]         bresp;
  logic               bvalid, bready;
  logic               cfg_enable, cfg_clear;
  logic [ADDR_W-1:0]  cfg_base, cfg_mask;
  logic [ADDR_W-1:0]  stat_offset;
  logic [31:0]        stat_wraps;
  logic               stat_err, stat_busy;

  always #5 aclk = ~aclk;

  trace_axis_mem_sink dut (
    .aclk(aclk), .aresetn(aresetn),
    .s_axis_trace_tvalid(tvalid), .s_axis_trace_tready(tready),
    .s_axis_trace_tdata(tdata), .s_axis_trace_tkeep(tkeep), .s_axis_trace_tlast(tlast),
    .m_axi_awid(awid), .m_axi_awaddr(awaddr), .m_axi_awlen(awlen), .m_axi_awsize(awsize),
    .m_axi_awburst(awburst), .m_axi_awvalid(awvalid), .m_axi_awready(awready),
    .m_axi_wdata(wdata), .m_axi_wstrb(wstrb), .m_axi_wlast(wlast),
    .m_axi_wvalid(wvalid), .m_axi_wready(wready),
    .m_axi_bid(bid), .m_axi_bresp(bresp), .m_axi_bvalid(bvalid), .m_axi_bready(bready),
    .cfg_enable(cfg_enable), .cfg_base(cfg_base), .cfg_mask(cfg_mask), .cfg_clear(cfg_clear),
    .stat_offset(stat_offset), .stat_wraps(stat_wraps), .stat_err(stat_err), .stat_busy(stat_busy)
  );

  int n_chk = 0;
  int n_pass = 0;
  int n_fail = 0;

  // Reference model: ring position and status, plus the beats of the burst being staged.
  logic [ADDR_W-1:0] m_off;
  logic [31:0]       m_wraps;
  logic              m_err;
  logic [IN_W-1:0]   q_data [$];
  logic [IN_W/8-1:0] q_keep [$];

  task automatic check(input string tag, input logic [511:0] obs, input logic [511:0] exp);
    n_chk++;
    assert (obs === exp) n_pass++;
    else begin
      n_fail++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge aclk);
    #1;
  endtask

  function automatic logic [IN_W-1:0] rand_wide();
    logic [IN_W-1:0] v;
    for (int i = 0; i < IN_W / 32; i++) v[i*32 +: 32] = $urandom;
    return v;
  endfunction

  task automatic model_reset();
    m_off = '0;
    m_wraps = '0;
    m_err = 1'b0;
  endtask

  task automatic check_reset_outputs(input string tag);
    check({tag, "_tready"}, tready, 0);
    check({tag, "_awvalid"}, awvalid, 0);
    check({tag, "_wvalid"}, wvalid, 0);
    check({tag, "_wlast"}, wlast, 0);
    check({tag, "_bready"}, bready, 0);
    check({tag, "_offset"}, stat_offset, 0);
    check({tag, "_wraps"}, stat_wraps, 0);
    check({tag, "_err"}, stat_err, 0);
    check({tag, "_busy"}, stat_busy, 0);
  endtask

  task automatic send_beats(input int n, input bit force_tlast);
    logic [IN_W-1:0]   d;
    logic [IN_W/8-1:0] kp;
    int b;
    q_data.delete();
    q_keep.delete();
    for (int i = 0; i < n; i++) begin
      d = rand_wide();
      kp = ($urandom_range(0, 1) == 1) ? '1 : {$urandom, $urandom};
      q_data.push_back(d);
      q_keep.push_back(kp);
      tdata = d;
      tkeep = kp;
      tlast = (i == n - 1) && ((n < DEPTH) || force_tlast);
      tvalid = 1'b1;
      #1;
      b = 0;
      while (!tready && b < 100) begin
        tick();
        b++;
      end
      check("s_tready", tready, 1);
      if (!tready) begin
        tvalid = 1'b0;
        return;
      end
      tick();
    end
    tvalid = 1'b0;
    tlast = 1'b0;
  endtask

  task automatic do_aw(input int delay);
    logic [ADDR_W-1:0] ea;
    ea = cfg_base + m_off;
    check("awvalid", awvalid, 1);
    check("awaddr", awaddr, ea);
    check("awlen", awlen, 15);
    check("awsize", awsize, 5);
    check("awburst", awburst, 1);
    check("awid", awid, 0);
    check("aw_wvalid", wvalid, 0);
    for (int i = 0; i < delay; i++) begin
      awready = 1'b0;
      tick();
      check("aw_hold_valid", awvalid, 1);
      check("aw_hold_addr", awaddr, ea);
      check("aw_hold_tready", tready, 0);
      check("aw_hold_wvalid", wvalid, 0);
    end
    awready = 1'b1;
    tick();
    awready = 1'b0;
  endtask

  // Returns early (with reset asserted) when abort_k names a beat.
  task automatic do_w(input int abort_k);
    logic [IN_W-1:0] d;
    logic [IN_W/8-1:0] kp;
    logic [MEM_W-1:0] ed;
    logic [MEM_W/8-1:0] es;
    int b, e;
    for (int k = 0; k < BB; k++) begin
      b = 0;
      wready = ($urandom_range(0, 3) != 0);
      while (!(wready && wvalid) && b < 100) begin
        tick();
        wready = ($urandom_range(0, 3) != 0);
        b++;
      end
      check("w_valid", wvalid, 1);
      if (!wvalid) return;
      if (k == abort_k) begin
        aresetn = 1'b0;
        #1;
        check_reset_outputs("mid_reset");
        wready = 1'b0;
        return;
      end
      e = k / 2;
      ed = '0;
      es = '0;
      if (e < q_data.size()) begin
        d = q_data[e];
        kp = q_keep[e];
        ed = (k % 2 == 1) ? d[511:256] : d[255:0];
        es = (k % 2 == 1) ? kp[63:32] : kp[31:0];
      end
      check("wdata", wdata, ed);
      check("wstrb", wstrb, es);
      check("wlast", wlast, (k == BB - 1));
      tick();
    end
    wready = 1'b0;
  endtask

  task automatic do_b(input logic [1:0] resp);
    int dly;
    check("bready", bready, 1);
    check("b_wvalid", wvalid, 0);
    dly = $urandom_range(0, 3);
    for (int i = 0; i < dly; i++) begin
      tick();
      check("b_hold_bready", bready, 1);
    end
    bvalid = 1'b1;
    bresp = resp;
    tick();
    bvalid = 1'b0;
    bresp = 2'b00;
    m_err = m_err | (resp != 2'b00);
    m_off = (m_off + 48'd512) & cfg_mask;
    if (m_off == '0 && m_wraps != 32'hFFFF_FFFF) m_wraps = m_wraps + 1;
    check("stat_offset", stat_offset, m_off);
    check("stat_wraps", stat_wraps, m_wraps);
    check("stat_err", stat_err, m_err);
    check("post_busy", stat_busy, 0);
    check("post_bready", bready, 0);
  endtask

  task automatic run_burst(input int n, input bit force_tlast, input int aw_delay, input logic [1:0] resp);
    send_beats(n, force_tlast);
    do_aw(aw_delay);
    do_w(-1);
    do_b(resp);
  endtask

  task automatic do_clear();
    cfg_clear = 1'b1;
    #1;
    check("clear_tready", tready, 0);
    tick();
    cfg_clear = 1'b0;
    model_reset();
    check("clear_offset", stat_offset, 0);
    check("clear_wraps", stat_wraps, 0);
    check("clear_err", stat_err, 0);
  endtask

  initial begin
    #500_000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    aresetn = 1'b0;
    tvalid = 0; tlast = 0; tdata = '0; tkeep = '0;
    awready = 0; wready = 0; bvalid = 0; bresp = 0; bid = '0;
    cfg_enable = 1'b1; cfg_clear = 1'b0;
    cfg_base = 48'h1_0000_0000;
    cfg_mask = 48'hFFFF;
    model_reset();
    tick();
    check_reset_outputs("reset");
    tick();
    aresetn = 1'b1;

    // 1) eight full beats fill one burst
    run_burst(8, 1'b0, 0, 2'b00);
    check("t1_offset", stat_offset, 48'h200);

    // 2) tlast on the third beat flushes a padded burst
    run_burst(3, 1'b0, 0, 2'b00);

    // 3) small ring wraps after two bursts
    do_clear();
    cfg_mask = 48'h3FF;
    run_burst(8, 1'b1, 0, 2'b00);
    run_burst($urandom_range(1, 8), 1'b1, 1, 2'b00);
    run_burst($urandom_range(1, 8), 1'b0, 2, 2'b00);
    check("t3_wraps", stat_wraps, 1);
    check("t3_offset", stat_offset, 48'h200);

    // 4) long AW stall
    run_burst(8, 1'b0, 20, 2'b00);

    // 5) error response is sticky, offset still advances
    do_clear();
    cfg_mask = 48'hFFFF;
    run_burst(5, 1'b0, 0, 2'b10);
    run_burst(8, 1'b0, 0, 2'b00);
    check("t5_err", stat_err, 1);
    check("t5_offset", stat_offset, 48'h400);

    // disabled: no beat accepted, block stays idle
    cfg_enable = 1'b0;
    tvalid = 1'b1;
    #1;
    check("dis_tready", tready, 0);
    tick();
    check("dis_busy", stat_busy, 0);
    tvalid = 1'b0;
    cfg_enable = 1'b1;

    // 6) reset during DATA beat 5, then a fresh burst at offset 0
    send_beats(8, 1'b0);
    do_aw(0);
    do_w(5);
    tick();
    aresetn = 1'b1;
    model_reset();
    run_burst(6, 1'b0, 1, 2'b00);
    check("t6_offset", stat_offset, 48'h200);

    // randomized bursts
    for (int i = 0; i < 6; i++) begin
      run_burst($urandom_range(1, 8), 1'($urandom_range(0, 1)), $urandom_range(0, 3),
                ($urandom_range(0, 3) == 0) ? 2'b10 : 2'b00);
    end

    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end
endmodule
